countdown_sequencer: RTL

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

---
 rtl/countdown_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/countdown_sequencer.sv
// Loadable down-counter with run/pause/done sequencing, optional auto-reload
// and a registered terminal-count pulse.
module countdown_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             start_ok;

  // A start carrying a zero load value is treated as if start were low.
  assign start_ok = start && (load_val != '0);

  // Next-state: stop beats start beats pause; tc only on the 1 -> 0 step.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (stop) begin
      state_d = StIdle;
      count_d = '0;
    end else if (start_ok) begin
      state_d  = StRun;
      count_d  = load_val;
      reload_d = load_val;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pause) begin
            state_d = StPaused;
          end else if (count_q > CountOne) begin
            count_d = count_q - CountOne;
          end else if (count_q == CountOne) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else if (auto_reload) begin
            count_d = reload_q;
          end else begin
            state_d = StDone;
          end
        end
        StPaused: begin
          // Count is held on the return cycle; decrement resumes after it.
          if (!pause) state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset overriding every command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun) || (state_q == StPaused);
  assign done  = (state_q == StDone);

endmodule
